// File: rtl/key_event_bank_if.sv
// key_event_bank_if
// Groups the key-conditioner signals into one bundle.
//   i_in        raw asynchronous key levels (one bit per channel)
//   i_repeat_en per-channel auto-repeat enable, synchronous to the clock
//   o_pressed   debounced pressed state (1 = pressed)
//   o_press     one-cycle pulse on accepted press
//   o_release   one-cycle pulse on accepted release
//   o_long      one-cycle pulse when a hold reaches the long-press time
//   o_repeat    one-cycle auto-repeat pulse
// The master drives the key inputs and consumes the events; the slave is
// the conditioner itself.
interface key_event_bank_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] i_in;
    logic [N_CH-1:0] i_repeat_en;
    logic [N_CH-1:0] o_pressed;
    logic [N_CH-1:0] o_press;
    logic [N_CH-1:0] o_release;
    logic [N_CH-1:0] o_long;
    logic [N_CH-1:0] o_repeat;

    modport master (
        output i_in, i_repeat_en,
        input  o_pressed, o_press, o_release, o_long, o_repeat
    );

    modport slave (
        input  i_in, i_repeat_en,
        output o_pressed, o_press, o_release, o_long, o_repeat
    );
endinterface

// File: rtl/key_event_bank.sv
// key_event_bank
// Multi-channel push-button conditioner. Each channel has a two-flop
// synchroniser, a stability-counter debouncer and a hold timer that turns
// a held key into press, release, long-press and auto-repeat pulses.
// Ports:
//   i_clk  sole clock
//   i_rst  asynchronous, active-high reset
//   bus    key_event_bank_if.slave: raw keys and repeat enables in,
//          debounced state and one-cycle event pulses out (all registered)
module key_event_bank #(
    parameter int N_CH          = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int DEB_CYCLES    = 50000,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    key_event_bank_if.slave bus
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

    // Raw level of a released key; also the XOR mask that turns a
    // synchronised raw level into "pressed".
    localparam logic IDLE_LVL = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } hold_state_e;

    logic [N_CH-1:0] s1_q, s2_q;
    logic [N_CH-1:0] pressed_w, press_w, release_w, long_w, repeat_w;

    // Synchronisers reset to the released level so a key held through
    // reset is seen as a fresh press afterwards.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_q <= {N_CH{IDLE_LVL}};
            s2_q <= {N_CH{IDLE_LVL}};
        end else begin
            s1_q <= bus.i_in;
            s2_q <= s1_q;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        hold_state_e   state_q, state_d;
        logic [DW-1:0] deb_q, deb_d;
        logic [HW-1:0] hold_q, hold_d;
        logic [RW-1:0] rpt_q, rpt_d;
        logic          pressed_q, pressed_d;
        logic          press_q, press_d;
        logic          release_q, release_d;
        logic          long_q, long_d;
        logic          rpt_pulse_q, rpt_pulse_d;
        logic          p;
        logic          accept;

        assign p = s2_q[c] ^ IDLE_LVL;

        always_comb begin
            state_d     = state_q;
            deb_d       = deb_q;
            hold_d      = hold_q;
            rpt_d       = rpt_q;
            pressed_d   = pressed_q;
            press_d     = 1'b0;
            release_d   = 1'b0;
            long_d      = 1'b0;
            rpt_pulse_d = 1'b0;
            accept      = 1'b0;

            // Count consecutive samples that disagree with the accepted
            // state; any agreeing sample throws the partial count away.
            if (p != pressed_q) begin
                if (deb_q == DEB_LAST) begin
                    accept    = 1'b1;
                    pressed_d = p;
                    deb_d     = '0;
                    press_d   = p;
                    release_d = ~p;
                end else begin
                    deb_d = deb_q + DW'(1);
                end
            end else begin
                deb_d = '0;
            end

            // A release overrides everything so long/repeat can never
            // coincide with or follow the release edge.
            if (accept && !p) begin
                state_d = ST_IDLE;
                hold_d  = '0;
                rpt_d   = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept && p) begin
                            state_d = ST_HOLD;
                            hold_d  = '0;
                        end
                    end
                    ST_HOLD: begin
                        if (hold_q == LONG_LAST) begin
                            long_d  = 1'b1;
                            rpt_d   = '0;
                            state_d = ST_REPEAT;
                        end else begin
                            hold_d = hold_q + HW'(1);
                        end
                    end
                    ST_REPEAT: begin
                        // Holding the phase at 0 while disabled makes the
                        // first repeat land a full period after re-enable.
                        if (!bus.i_repeat_en[c]) begin
                            rpt_d = '0;
                        end else if (rpt_q == REP_LAST) begin
                            rpt_pulse_d = 1'b1;
                            rpt_d       = '0;
                        end else begin
                            rpt_d = rpt_q + RW'(1);
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                        rpt_d   = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                state_q     <= ST_IDLE;
                deb_q       <= '0;
                hold_q      <= '0;
                rpt_q       <= '0;
                pressed_q   <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
                long_q      <= 1'b0;
                rpt_pulse_q <= 1'b0;
            end else begin
                state_q     <= state_d;
                deb_q       <= deb_d;
                hold_q      <= hold_d;
                rpt_q       <= rpt_d;
                pressed_q   <= pressed_d;
                press_q     <= press_d;
                release_q   <= release_d;
                long_q      <= long_d;
                rpt_pulse_q <= rpt_pulse_d;
            end
        end

        assign pressed_w[c] = pressed_q;
        assign press_w[c]   = press_q;
        assign release_w[c] = release_q;
        assign long_w[c]    = long_q;
        assign repeat_w[c]  = rpt_pulse_q;
    end

    assign bus.o_pressed = pressed_w;
    assign bus.o_press   = press_w;
    assign bus.o_release = release_w;
    assign bus.o_long    = long_w;
    assign bus.o_repeat  = repeat_w;
endmodule

// File: tb/tb_key_event_bank.sv
module tb_key_event_bank;
    localparam int N    = 4;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 5;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    key_event_bank_if #(.N_CH(N)) kif ();

    key_event_bank #(
        .N_CH(N), .ACTIVE_LOW(1), .DEB_CYCLES(DEB),
        .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // Reference model: elapsed-time view of each key.
    logic [N-1:0] m_pressed, m_press, m_rel, m_long, m_rep;
    logic [N-1:0] m_dl1, m_dl2, m_last_p, m_long_done;
    int           m_run[N];
    int           m_press_t[N];
    int           m_anchor[N];
    int           cyc;

    wire [19:0] dut_o = {kif.o_pressed, kif.o_press, kif.o_release, kif.o_long, kif.o_repeat};
    wire [19:0] mdl_o = {m_pressed, m_press, m_rel, m_long, m_rep};

    function automatic void model_reset();
        m_pressed   = '0; m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
        m_dl1       = '1; m_dl2 = '1;
        m_last_p    = '0; m_long_done = '0;
        for (int c = 0; c < N; c++) begin
            m_run[c] = 0; m_press_t[c] = 0; m_anchor[c] = 0;
        end
    endfunction

    // Pressed sample reaches the debouncer two edges after the raw input;
    // a level change is accepted once the new level has been seen DEB
    // times in a row. Long fires LONG cycles after the press; repeats
    // fire every REP cycles of uninterrupted enable after the long event.
    function automatic void model_step();
        logic p;
        if (rst) begin
            model_reset();
            return;
        end
        cyc++;
        m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
        for (int c = 0; c < N; c++) begin
            p = ~m_dl2[c];
            if (p == m_last_p[c]) m_run[c]++;
            else m_run[c] = 1;
            m_last_p[c] = p;
            if (p != m_pressed[c] && m_run[c] >= DEB) begin
                m_pressed[c] = p;
                if (p) begin
                    m_press[c]   = 1'b1;
                    m_press_t[c] = cyc;
                end else begin
                    m_rel[c]       = 1'b1;
                    m_long_done[c] = 1'b0;
                end
            end else if (m_pressed[c]) begin
                if (!m_long_done[c]) begin
                    if (cyc - m_press_t[c] == LONG) begin
                        m_long[c]      = 1'b1;
                        m_long_done[c] = 1'b1;
                        m_anchor[c]    = cyc;
                    end
                end else if (!kif.i_repeat_en[c]) begin
                    m_anchor[c] = cyc;
                end else if (cyc - m_anchor[c] == REP) begin
                    m_rep[c]    = 1'b1;
                    m_anchor[c] = cyc;
                end
            end
        end
        m_dl2 = m_dl1;
        m_dl1 = kif.i_in;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        int press_tick = 0;
        int press_cycles = 0;
        logic [N-1:0] press_val = '0;
        rst = 1'b1;
        kif.i_in = 4'b0000;
        kif.i_repeat_en = '0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            if (dut_o !== 20'h0) begin
                failures++;
                $display("FAIL reset_hold cycle=%0d got=%h want=%h", i, dut_o, 20'h0);
            end
            checks++;
        end
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (dut_o !== mdl_o) begin
                failures++;
                $display("FAIL reset_model tick=%0d got=%h want=%h", i, dut_o, mdl_o);
            end
            checks++;
            if (kif.o_press != 0) begin
                press_cycles++;
                if (press_tick == 0) begin
                    press_tick = i;
                    press_val  = kif.o_press;
                end
            end
        end
        if (press_tick !== 6) begin
            failures++;
            $display("FAIL reset_press_tick got=%0d want=6", press_tick);
        end
        checks++;
        if (press_val !== 4'b1111) begin
            failures++;
            $display("FAIL reset_press_val got=%b want=1111", press_val);
        end
        checks++;
        if (press_cycles !== 1) begin
            failures++;
            $display("FAIL reset_press_width got=%0d want=1", press_cycles);
        end
        checks++;
        kif.i_in = 4'b1111;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (dut_o !== mdl_o) begin
                failures++;
                $display("FAIL reset_release tick=%0d got=%h want=%h", i, dut_o, mdl_o);
            end
            checks++;
        end
        if (kif.o_pressed !== 4'b0000) begin
            failures++;
            $display("FAIL reset_all_released got=%b want=0000", kif.o_pressed);
        end
        checks++;
    endtask

    task automatic test_glitch();
        int presses = 0;
        int press_tick = 0;
        int rel_tick = 0;
        kif.i_in[0] = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (dut_o !== mdl_o) begin
                failures++;
                $display("FAIL glitch3_model tick=%0d got=%h want=%h", i, dut_o, mdl_o);
            end
            checks++;
            if (kif.o_press[0]) presses++;
            if (i == 3) kif.i_in[0] = 1'b1;
        end
        if (presses !== 0) begin
            failures++;
            $display("FAIL glitch3_press got=%0d want=0", presses);
        end
        checks++;
        kif.i_in[0] = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (dut_o !== mdl_o) begin
                failures++;
                $display("FAIL glitch4_model tick=%0d got=%h want=%h", i, dut_o, mdl_o);
            end
            checks++;
            if (kif.o_press[0]) begin
                presses++;
                press_tick = i;
            end
            if (kif.o_release[0]) rel_tick = i;
            if (i == 4) kif.i_in[0] = 1'b1;
        end
        if (presses !== 1 || press_tick !== 6) begin
            failures++;
            $display("FAIL glitch4_press count=%0d tick=%0d want count=1 tick=6", presses, press_tick);
        end
        checks++;
        if (rel_tick !== 10) begin
            failures++;
            $display("FAIL glitch4_release tick got=%0d want=10", rel_tick);
        end
        checks++;
    endtask

    task automatic test_long_repeat();
        int p_t = 0;
        int long_t = 0;
        int rel_t = 0;
        int late = 0;
        int rep_q[$];
        kif.i_repeat_en[1] = 1'b1;
        kif.i_in[1] = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (dut_o !== mdl_o) begin
                failures++;
                $display("FAIL long_rep_model tick=%0d got=%h want=%h", i, dut_o, mdl_o);
            end
            checks++;
            if (kif.o_press[1]) p_t = i;
            if (kif.o_long[1]) long_t = i;
            if (kif.o_repeat[1]) rep_q.push_back(i);
            if (kif.o_release[1]) rel_t = i;
            if (rel_t != 0 && (kif.o_long[1] || kif.o_repeat[1])) late++;
            if (p_t != 0 && i == p_t + 36) kif.i_in[1] = 1'b1;
        end
        if (p_t !== 6 || long_t !== p_t + LONG) begin
            failures++;
            $display("FAIL long_time press=%0d long=%0d want press=6 long=%0d", p_t, long_t, 6 + LONG);
        end
        checks++;
        if (rep_q.size() !== 4) begin
            failures++;
            $display("FAIL repeat_count got=%0d want=4", rep_q.size());
        end
        checks++;
        for (int k = 0; k < 4; k++) begin
            if (k >= rep_q.size() || rep_q[k] !== 6 + 25 + 5 * k) begin
                failures++;
                $display("FAIL repeat_time idx=%0d got=%0d want=%0d", k,
                         (k < rep_q.size()) ? rep_q[k] : -1, 6 + 25 + 5 * k);
            end
            checks++;
        end
        if (rel_t !== 6 + 42) begin
            failures++;
            $display("FAIL long_release tick got=%0d want=%0d", rel_t, 6 + 42);
        end
        checks++;
        if (late !== 0) begin
            failures++;
            $display("FAIL pulse_after_release got=%0d want=0", late);
        end
        checks++;
        kif.i_repeat_en[1] = 1'b0;
    endtask

    task automatic test_repeat_disabled();
        int p_t = 0;
        int longs = 0;
        int reps = 0;
        int rep_q[$];
        kif.i_repeat_en[2] = 1'b0;
        kif.i_in[2] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (dut_o !== mdl_o) begin
                failures++;
                $display("FAIL rep_dis_model tick=%0d got=%h want=%h", i, dut_o, mdl_o);
            end
            checks++;
            if (kif.o_press[2]) p_t = i;
            if (kif.o_long[2]) longs++;
            if (kif.o_repeat[2]) reps++;
            if (p_t != 0 && i == p_t + 60) kif.i_in[2] = 1'b1;
        end
        if (longs !== 1 || reps !== 0) begin
            failures++;
            $display("FAIL rep_dis_counts long=%0d repeat=%0d want long=1 repeat=0", longs, reps);
        end
        checks++;
        p_t = 0;
        kif.i_in[2] = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (dut_o !== mdl_o) begin
                failures++;
                $display("FAIL rep_reen_model tick=%0d got=%h want=%h", i, dut_o, mdl_o);
            end
            checks++;
            if (kif.o_press[2]) p_t = i;
            if (kif.o_repeat[2]) rep_q.push_back(i);
            if (p_t != 0 && i == p_t + 30) kif.i_repeat_en[2] = 1'b1;
            if (p_t != 0 && i == p_t + 42) kif.i_in[2] = 1'b1;
        end
        if (rep_q.size() < 2 || rep_q[0] !== p_t + 35 || rep_q[1] !== p_t + 40) begin
            failures++;
            $display("FAIL rep_reenable n=%0d first=%0d want first=%0d second=%0d", rep_q.size(),
                     (rep_q.size() > 0) ? rep_q[0] : -1, p_t + 35, p_t + 40);
        end
        checks++;
        kif.i_repeat_en[2] = 1'b0;
    endtask

    task automatic test_release_bounce();
        logic pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        int rel_t = 0;
        int rels = 0;
        kif.i_in[3] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (dut_o !== mdl_o) begin
                failures++;
                $display("FAIL bounce_press_model tick=%0d got=%h want=%h", i, dut_o, mdl_o);
            end
            checks++;
        end
        for (int i = 1; i <= 14; i++) begin
            kif.i_in[3] = (i <= 6) ? pat[i-1] : 1'b1;
            tick();
            if (dut_o !== mdl_o) begin
                failures++;
                $display("FAIL bounce_model tick=%0d got=%h want=%h", i, dut_o, mdl_o);
            end
            checks++;
            if (i < 8) begin
                if (kif.o_pressed[3] !== 1'b1) begin
                    failures++;
                    $display("FAIL bounce_held tick=%0d got=%b want=1", i, kif.o_pressed[3]);
                end
                checks++;
            end
            if (kif.o_release[3]) begin
                rels++;
                rel_t = i;
            end
        end
        if (rels !== 1 || rel_t !== 8) begin
            failures++;
            $display("FAIL bounce_release count=%0d tick=%0d want count=1 tick=8", rels, rel_t);
        end
        checks++;
    endtask

    task automatic test_reset_mid_hold();
        int p_t = 0;
        int long_t = 0;
        int rels = 0;
        kif.i_repeat_en[1] = 1'b1;
        kif.i_in[1] = 1'b0;
        for (int i = 1; i <= 36; i++) begin
            tick();
            if (dut_o !== mdl_o) begin
                failures++;
                $display("FAIL midhold_model tick=%0d got=%h want=%h", i, dut_o, mdl_o);
            end
            checks++;
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        if (dut_o !== 20'h0) begin
            failures++;
            $display("FAIL async_clear got=%h want=%h", dut_o, 20'h0);
        end
        checks++;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (dut_o !== 20'h0) begin
                failures++;
                $display("FAIL midhold_in_reset got=%h want=%h", dut_o, 20'h0);
            end
            checks++;
        end
        rst = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (dut_o !== mdl_o) begin
                failures++;
                $display("FAIL post_reset_model tick=%0d got=%h want=%h", i, dut_o, mdl_o);
            end
            checks++;
            if (kif.o_press[1]) p_t = i;
            if (kif.o_long[1]) long_t = i;
            if (kif.o_release[1]) rels++;
        end
        if (p_t !== 6 || long_t !== 6 + LONG || rels !== 0) begin
            failures++;
            $display("FAIL post_reset_hold press=%0d long=%0d rel=%0d want press=6 long=%0d rel=0",
                     p_t, long_t, rels, 6 + LONG);
        end
        checks++;
        kif.i_in = 4'b1111;
        kif.i_repeat_en = '0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (dut_o !== mdl_o) begin
                failures++;
                $display("FAIL final_release_model tick=%0d got=%h want=%h", i, dut_o, mdl_o);
            end
            checks++;
        end
    endtask

    // Random traffic on all channels against the reference model.
    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) kif.i_in = 4'($urandom);
            if ($urandom_range(0, 19) == 0) kif.i_repeat_en = 4'($urandom);
            tick();
            if (dut_o !== mdl_o) begin
                failures++;
                $display("FAIL random_model cycle=%0d got=%h want=%h", i, dut_o, mdl_o);
            end
            checks++;
        end
    endtask

    initial begin
        cyc = 0;
        rst = 1'b1;
        kif.i_in = 4'b1111;
        kif.i_repeat_en = '0;
        model_reset();
        test_reset();
        test_glitch();
        test_long_repeat();
        test_repeat_disabled();
        test_release_bounce();
        test_reset_mid_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
